fabric_config_loader: RTL and testbench



---
 rtl/fabric_config_pkg.sv | 23 ++
 rtl/fabric_config_loader_if.sv | 14 +
 rtl/fabric_config_loader.sv | 134 +++++++++++++
 tb/tb_fabric_config_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_config_pkg.sv
// Shared fabric configuration constants: block selects, stream magic and the
// loader FSM encoding. Used by the loader and by every tile decoder.
package fabric_config_pkg;

    localparam logic [15:0] CONFIG_SB  = 16'd7;
    localparam logic [15:0] CONFIG_CB0 = 16'd6;
    localparam logic [15:0] CONFIG_CB1 = 16'd5;
    localparam logic [15:0] CONFIG_CLB = 16'd4;

    localparam logic [15:0] CFG_MAGIC     = 16'hC0F1;
    // No tile decodes this address, so config_en stays low while it is driven.
    localparam logic [31:0] CFG_IDLE_ADDR = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } cfg_state_e;

endpackage

// File: rtl/fabric_config_loader_if.sv
// Bitstream word stream from the host/boot side into the config loader.
interface fabric_config_loader_if;

    // A word transfers on a rising clk edge where in_valid && in_ready. The
    // master holds in_data stable while in_valid is high and not yet accepted;
    // in_ready may change regardless of in_valid.
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/fabric_config_loader.sv
// Parses a {magic,N} header plus N (addr,data) records and drives each pair onto
// the shared tile config bus for WRITE_CYCLES cycles, idling in between.
module fabric_config_loader
    import fabric_config_pkg::*;
#(
    parameter int          WRITE_CYCLES = 1,
    parameter logic [31:0] IDLE_ADDR    = CFG_IDLE_ADDR,
    parameter logic [15:0] MAGIC        = CFG_MAGIC
) (
    input  logic                         clk,
    input  logic                         reset,
    fabric_config_loader_if.slave        bs,
    input  logic                         clear,
    output logic [31:0]                  config_addr,
    output logic [31:0]                  config_data,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [15:0]                  writes_done,
    output cfg_state_e                   state
);

    localparam logic [3:0] HOLD_INIT = 4'(WRITE_CYCLES);

    cfg_state_e  state_q;
    logic        in_ready_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [31:0] config_addr_q;
    logic [31:0] config_data_q;
    logic [15:0] writes_done_q;
    logic [15:0] n_q;
    logic [31:0] addr_q;
    logic [3:0]  hold_q;
    logic        accept;

    assign accept      = bs.in_valid && in_ready_q;
    assign bs.in_ready = in_ready_q;
    assign config_addr = config_addr_q;
    assign config_data = config_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign writes_done = writes_done_q;
    assign state       = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            config_addr_q <= IDLE_ADDR;
            config_data_q <= '0;
            writes_done_q <= '0;
            n_q           <= '0;
            addr_q        <= '0;
            hold_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (bs.in_data[31:16] != MAGIC) begin
                            state_q    <= ST_ERROR;
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b0;
                        end else if (bs.in_data[15:0] == 16'd0) begin
                            state_q       <= ST_DONE;
                            done_q        <= 1'b1;
                            writes_done_q <= '0;
                            in_ready_q    <= 1'b0;
                        end else begin
                            state_q       <= ST_ADDR;
                            n_q           <= bs.in_data[15:0];
                            writes_done_q <= '0;
                            busy_q        <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (accept) begin
                        addr_q  <= bs.in_data;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        config_addr_q <= addr_q;
                        config_data_q <= bs.in_data;
                        hold_q        <= HOLD_INIT;
                        in_ready_q    <= 1'b0;
                        state_q       <= ST_WRITE;
                    end
                end
                // hold_q counts remaining bus cycles; at zero the bus is already
                // idle and this extra cycle guarantees write-to-write spacing.
                ST_WRITE: begin
                    if (hold_q > 4'd1) begin
                        hold_q <= hold_q - 4'd1;
                    end else if (hold_q == 4'd1) begin
                        hold_q        <= '0;
                        config_addr_q <= IDLE_ADDR;
                        config_data_q <= '0;
                        writes_done_q <= writes_done_q + 16'd1;
                    end else if (writes_done_q == n_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= ST_ADDR;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (clear) begin
                        state_q    <= ST_IDLE;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Bench for fabric_config_loader: three instances (WRITE_CYCLES 1, 3, 4) checked
// every cycle against a stream-level model, plus directed literal checks.
module tb_fabric_config_loader;
  import fabric_config_pkg::*;

  localparam logic [31:0] IDLE = CFG_IDLE_ADDR;
  localparam int WCS [3] = '{1, 3, 4};
  localparam int WANT_HDR = 0, WANT_ADDR = 1, WANT_DATA = 2, WRITING = 3, FIN_OK = 4, FIN_BAD = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [3];
  logic        clr       [3];
  logic        drv_valid [3];
  logic [31:0] drv_data  [3];
  logic        rdy_w     [3];
  logic [31:0] o_addr    [3];
  logic [31:0] o_data    [3];
  logic        o_busy    [3];
  logic        o_done    [3];
  logic        o_err     [3];
  logic [15:0] o_wd      [3];
  cfg_state_e  o_state   [3];

  int total = 0;
  int bad = 0;

  fabric_config_loader_if sif0 ();
  fabric_config_loader_if sif1 ();
  fabric_config_loader_if sif2 ();
  assign sif0.in_valid = drv_valid[0];
  assign sif0.in_data  = drv_data[0];
  assign rdy_w[0]      = sif0.in_ready;
  assign sif1.in_valid = drv_valid[1];
  assign sif1.in_data  = drv_data[1];
  assign rdy_w[1]      = sif1.in_ready;
  assign sif2.in_valid = drv_valid[2];
  assign sif2.in_data  = drv_data[2];
  assign rdy_w[2]      = sif2.in_ready;

  fabric_config_loader #(.WRITE_CYCLES(1)) u0 (
    .clk(clk), .reset(rst[0]), .bs(sif0), .clear(clr[0]),
    .config_addr(o_addr[0]), .config_data(o_data[0]), .busy(o_busy[0]),
    .done(o_done[0]), .error(o_err[0]), .writes_done(o_wd[0]), .state(o_state[0])
  );
  fabric_config_loader #(.WRITE_CYCLES(3)) u1 (
    .clk(clk), .reset(rst[1]), .bs(sif1), .clear(clr[1]),
    .config_addr(o_addr[1]), .config_data(o_data[1]), .busy(o_busy[1]),
    .done(o_done[1]), .error(o_err[1]), .writes_done(o_wd[1]), .state(o_state[1])
  );
  fabric_config_loader #(.WRITE_CYCLES(4)) u2 (
    .clk(clk), .reset(rst[2]), .bs(sif2), .clear(clr[2]),
    .config_addr(o_addr[2]), .config_data(o_data[2]), .busy(o_busy[2]),
    .done(o_done[2]), .error(o_err[2]), .writes_done(o_wd[2]), .state(o_state[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stream-level model: which word is expected next, and the cycle window in
  // which the last accepted record must be visible on the bus.
  int          m_phase [3];
  logic [15:0] m_n     [3];
  logic [15:0] m_wd    [3];
  logic [31:0] m_pa    [3];
  logic [31:0] m_ba    [3];
  logic [31:0] m_bd    [3];
  logic        m_rdy   [3];
  logic        m_busy  [3];
  logic        m_done  [3];
  logic        m_err   [3];
  int          m_wend  [3];
  int          cyc;

  task automatic model_reset(input int k);
    m_phase[k] = WANT_HDR;
    m_n[k] = '0; m_wd[k] = '0; m_pa[k] = '0;
    m_ba[k] = IDLE; m_bd[k] = '0;
    m_rdy[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b0; m_err[k] = 1'b0;
    m_wend[k] = 0;
  endtask

  initial begin
    cyc = 0;
    for (int k = 0; k < 3; k++) model_reset(k);
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (rst[k]) begin
          model_reset(k);
        end else begin
          case (m_phase[k])
            WANT_HDR: if (drv_valid[k] && m_rdy[k]) begin
              if (drv_data[k][31:16] != CFG_MAGIC) begin
                m_phase[k] = FIN_BAD; m_err[k] = 1'b1;
              end else if (drv_data[k][15:0] == 16'd0) begin
                m_phase[k] = FIN_OK; m_done[k] = 1'b1; m_wd[k] = '0;
              end else begin
                m_phase[k] = WANT_ADDR; m_n[k] = drv_data[k][15:0]; m_wd[k] = '0;
              end
            end
            WANT_ADDR: if (drv_valid[k] && m_rdy[k]) begin
              m_pa[k] = drv_data[k]; m_phase[k] = WANT_DATA;
            end
            WANT_DATA: if (drv_valid[k] && m_rdy[k]) begin
              m_ba[k] = m_pa[k]; m_bd[k] = drv_data[k];
              m_wend[k] = cyc + WCS[k] - 1;
              m_phase[k] = WRITING;
            end
            WRITING: begin
              if (cyc == m_wend[k] + 1) begin
                m_ba[k] = IDLE; m_bd[k] = '0; m_wd[k] = m_wd[k] + 16'd1;
              end else if (cyc == m_wend[k] + 2) begin
                if (m_wd[k] == m_n[k]) begin m_phase[k] = FIN_OK; m_done[k] = 1'b1; end
                else m_phase[k] = WANT_ADDR;
              end
            end
            default: if (clr[k]) begin
              m_phase[k] = WANT_HDR; m_done[k] = 1'b0; m_err[k] = 1'b0;
            end
          endcase
          m_rdy[k]  = (m_phase[k] == WANT_HDR) || (m_phase[k] == WANT_ADDR) || (m_phase[k] == WANT_DATA);
          m_busy[k] = (m_phase[k] == WANT_ADDR) || (m_phase[k] == WANT_DATA) || (m_phase[k] == WRITING);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        chk($sformatf("u%0d.rst_addr", k), o_addr[k], IDLE);
        chk($sformatf("u%0d.rst_data", k), o_data[k], 32'h0);
        chk($sformatf("u%0d.rst_flags", k), {27'h0, rdy_w[k], o_busy[k], o_done[k], o_err[k], 1'b0}, 32'h0);
        chk($sformatf("u%0d.rst_wd", k), {16'h0, o_wd[k]}, 32'h0);
      end else begin
        chk($sformatf("u%0d.config_addr", k), o_addr[k], m_ba[k]);
        chk($sformatf("u%0d.config_data", k), o_data[k], m_bd[k]);
        chk($sformatf("u%0d.in_ready", k), {31'h0, rdy_w[k]}, {31'h0, m_rdy[k]});
        chk($sformatf("u%0d.busy", k), {31'h0, o_busy[k]}, {31'h0, m_busy[k]});
        chk($sformatf("u%0d.done", k), {31'h0, o_done[k]}, {31'h0, m_done[k]});
        chk($sformatf("u%0d.error", k), {31'h0, o_err[k]}, {31'h0, m_err[k]});
        chk($sformatf("u%0d.writes_done", k), {16'h0, o_wd[k]}, {16'h0, m_wd[k]});
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call only at posedge+#1; returns at posedge+#1 of the accepting edge.
  task automatic send_word(input int k, input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    drv_valid[k] = 1'b1;
    drv_data[k]  = w;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rdy_w[k]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    drv_valid[k] = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout u%0d: word %h not accepted in 100 cycles, want accepted", k, w);
    end
  endtask

  task automatic clear_pulse(input int k);
    clr[k] = 1'b1;
    sync();
    clr[k] = 1'b0;
  endtask

  task automatic wait_finish(input int k);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (o_done[k] || o_err[k]) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL finish_timeout u%0d: done=%b error=%b, want one set within 100 cycles", k, o_done[k], o_err[k]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; clr[k] = 1'b0; drv_valid[k] = 1'b0; drv_data[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_addr", o_addr[0], IDLE);
    chk("reset_ready", {31'h0, rdy_w[0]}, 32'h0);
    chk("reset_state", 32'(o_state[0]), 32'(ST_IDLE));
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    sync();
    @(negedge clk);
    chk("idle_ready", {31'h0, rdy_w[0]}, 32'h1);
    sync();

    // Single record, WRITE_CYCLES=1, in_valid held high.
    send_word(0, 32'hC0F1_0001);
    send_word(0, 32'h0007_0003);
    send_word(0, 32'h0000_00A5);
    @(negedge clk);
    chk("t1_addr", o_addr[0], 32'h0007_0003);
    chk("t1_data", o_data[0], 32'h0000_00A5);
    @(negedge clk);
    chk("t1_addr_idle", o_addr[0], IDLE);
    chk("t1_wd", {16'h0, o_wd[0]}, 32'd1);
    @(negedge clk);
    chk("t1_done", {31'h0, o_done[0]}, 32'h1);
    chk("t1_busy", {31'h0, o_busy[0]}, 32'h0);
    sync();
    clear_pulse(0);

    // Two records, WRITE_CYCLES=3: 3-cycle holds with an idle cycle between.
    send_word(1, 32'hC0F1_0002);
    send_word(1, 32'h0006_0001);
    send_word(1, 32'h0000_0002);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t2_hold0_%0d", i), o_addr[1], 32'h0006_0001);
      chk($sformatf("t2_data0_%0d", i), o_data[1], 32'h0000_0002);
    end
    @(negedge clk);
    chk("t2_gap_addr", o_addr[1], IDLE);
    chk("t2_wd1", {16'h0, o_wd[1]}, 32'd1);
    @(negedge clk);
    chk("t2_ready_again", {31'h0, rdy_w[1]}, 32'h1);
    sync();
    send_word(1, 32'h0004_0001);
    send_word(1, 32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t2_hold1_%0d", i), o_addr[1], 32'h0004_0001);
    end
    @(negedge clk);
    chk("t2_wd2", {16'h0, o_wd[1]}, 32'd2);
    @(negedge clk);
    chk("t2_done", {31'h0, o_done[1]}, 32'h1);
    sync();
    clear_pulse(1);

    // Bad magic, then clear; writes_done keeps its previous value.
    send_word(0, 32'hBEEF_0002);
    @(negedge clk);
    chk("t3_error", {31'h0, o_err[0]}, 32'h1);
    chk("t3_ready", {31'h0, rdy_w[0]}, 32'h0);
    chk("t3_addr", o_addr[0], IDLE);
    sync();
    clear_pulse(0);
    @(negedge clk);
    chk("t3_error_clr", {31'h0, o_err[0]}, 32'h0);
    chk("t3_ready_clr", {31'h0, rdy_w[0]}, 32'h1);
    chk("t3_wd_kept", {16'h0, o_wd[0]}, 32'd1);
    sync();

    // Empty stream.
    send_word(0, 32'hC0F1_0000);
    @(negedge clk);
    chk("t4_done", {31'h0, o_done[0]}, 32'h1);
    chk("t4_addr", o_addr[0], IDLE);
    chk("t4_wd", {16'h0, o_wd[0]}, 32'd0);
    sync();
    clear_pulse(0);

    // Backpressure gap between address and data words.
    send_word(0, 32'hC0F1_0002);
    send_word(0, 32'h0005_0002);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t5_gap_%0d", i), o_addr[0], IDLE);
    end
    sync();
    send_word(0, 32'h0000_0033);
    @(negedge clk);
    chk("t5_addr", o_addr[0], 32'h0005_0002);
    chk("t5_data", o_data[0], 32'h0000_0033);
    sync();
    send_word(0, 32'h0004_0009);
    send_word(0, 32'h0000_0077);
    wait_finish(0);
    chk("t5_wd", {16'h0, o_wd[0]}, 32'd2);
    sync();
    clear_pulse(0);

    // Reset during the second hold of a WRITE_CYCLES=4 stream.
    send_word(2, 32'hC0F1_0002);
    send_word(2, 32'h0007_000A);
    send_word(2, 32'h0000_1111);
    send_word(2, 32'h0006_000B);
    send_word(2, 32'h0000_1234);
    @(negedge clk);
    chk("t6_hold", o_addr[2], 32'h0006_000B);
    chk("t6_wd_before", {16'h0, o_wd[2]}, 32'd1);
    #2;
    rst[2] = 1'b1;
    #1;
    chk("t6_rst_addr", o_addr[2], IDLE);
    chk("t6_rst_busy", {31'h0, o_busy[2]}, 32'h0);
    chk("t6_rst_wd", {16'h0, o_wd[2]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b0;
    sync();
    send_word(2, 32'hC0F1_0001);
    send_word(2, 32'h0004_0005);
    send_word(2, 32'h0000_00EE);
    wait_finish(2);
    chk("t6_fresh_done", {31'h0, o_done[2]}, 32'h1);
    chk("t6_fresh_wd", {16'h0, o_wd[2]}, 32'd1);
    chk("t6_fresh_err", {31'h0, o_err[2]}, 32'h0);
    sync();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
